// File: rtl/maze_pkg.sv
// Shared maze geometry, FSM state encoding and wall-bus index helpers.
package maze_pkg;

  localparam int MAZE_COLS = 10;
  localparam int MAZE_ROWS = 15;
  localparam int H_W = (MAZE_ROWS + 1) * MAZE_COLS;
  localparam int V_W = MAZE_ROWS * (MAZE_COLS + 1);

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {IDLE, CLEAR, TOP, CELL, PICK, DONE} state_e;

  // Top edge of cell (r,c); row index ROWS addresses the bottom border.
  function automatic int h_idx(input int r, input int c, input int cols = MAZE_COLS);
    return r * cols + c;
  endfunction

  // Left edge of cell (r,c); column index COLS addresses the right border.
  function automatic int v_idx(input int r, input int c, input int cols = MAZE_COLS);
    return r * (cols + 1) + c;
  endfunction

endpackage

// File: rtl/maze_lfsr.sv
// Free-running 16-bit Galois LFSR; a zero seed is coerced to 1 so it never locks up.
module maze_lfsr
  import maze_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q <= SEED_NZ;
    end else begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/maze_generator.sv
// Sidewinder perfect-maze generator, one cell per cycle.
// Define MAZE_GEN_EXITS_EN to open an entrance at cell (0,0) top and an exit at the bottom-right cell.
module maze_generator
  import maze_pkg::*;
#(
  parameter int          COLS = MAZE_COLS,
  parameter int          ROWS = MAZE_ROWS,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         walls_valid,
  output logic [(ROWS+1)*COLS-1:0]     h_walls,
  output logic [ROWS*(COLS+1)-1:0]     v_walls
);

  localparam int HW  = (ROWS + 1) * COLS;
  localparam int VW  = ROWS * (COLS + 1);
  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int LW  = CW + 1;
  localparam int RW  = $clog2(ROWS + 1);
  localparam int HIW = $clog2(HW);
  localparam int VIW = $clog2(VW);
  // Interior left walls of row 0 (columns 1..COLS-1) opened by the TOP step.
  localparam logic [VW-1:0] TOP_OPEN = (VW'(1) << COLS) - VW'(2);

  state_e          state_q;
  logic            busy_q, done_q, valid_q;
  logic [HW-1:0]   hWalls_q;
  logic [VW-1:0]   vWalls_q;
  logic [RW-1:0]   row_q;
  logic [CW-1:0]   col_q, runStart_q;
  logic [LW-1:0]   len_q;

  logic [15:0]     lfsr;
  logic            rbit;
  logic [CW-1:0]   rpick;
  logic            unusedLfsrBits;

  maze_lfsr #(.SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign rbit           = lfsr[0];
  assign rpick          = lfsr[CW:1];
  assign unusedLfsrBits = ^lfsr[15:CW+1];

  logic            lastCol, lastRow, closeRun, accept;
  logic [HIW-1:0]  hCellIdx, hPickIdx;
  logic [VIW-1:0]  vRightIdx;
  logic [LW-1:0]   len_d;
  logic [CW-1:0]   col_d, runStartClosed_d, runStartKept_d;
  logic [RW-1:0]   row_d;
  state_e          stateAdv_d;

  // Shared "advance to next cell" values used by both CELL and PICK.
  always_comb begin
    lastCol          = (col_q == CW'(COLS - 1));
    lastRow          = (row_q == RW'(ROWS - 1));
    closeRun         = lastCol || !rbit;
    hCellIdx         = HIW'(h_idx(int'(row_q), int'(col_q), COLS));
    hPickIdx         = HIW'(h_idx(int'(row_q), int'(runStart_q) + int'(rpick), COLS));
    vRightIdx        = VIW'(v_idx(int'(row_q), int'(col_q) + 1, COLS));
    len_d            = ({1'b0, col_q} - {1'b0, runStart_q}) + LW'(1);
    accept           = ({1'b0, rpick} < len_q);
    col_d            = lastCol ? '0 : col_q + CW'(1);
    runStartClosed_d = lastCol ? '0 : col_q + CW'(1);
    runStartKept_d   = lastCol ? '0 : runStart_q;
    row_d            = lastCol ? row_q + RW'(1) : row_q;
    stateAdv_d       = (lastCol && lastRow) ? DONE : CELL;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      hWalls_q   <= '1;
      vWalls_q   <= '1;
      row_q      <= '0;
      col_q      <= '0;
      runStart_q <= '0;
      len_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        CLEAR: begin
          hWalls_q <= '1;
          vWalls_q <= '1;
          state_q  <= TOP;
        end
        TOP: begin
          vWalls_q   <= vWalls_q & ~TOP_OPEN;
          row_q      <= RW'(1);
          col_q      <= '0;
          runStart_q <= '0;
          state_q    <= (ROWS == 1) ? DONE : CELL;
        end
        CELL: begin
          if (closeRun) begin
            if (col_q == runStart_q) begin
              hWalls_q[hCellIdx] <= 1'b0;
              col_q              <= col_d;
              row_q              <= row_d;
              runStart_q         <= runStartClosed_d;
              state_q            <= stateAdv_d;
            end else begin
              len_q   <= len_d;
              state_q <= PICK;
            end
          end else begin
            vWalls_q[vRightIdx] <= 1'b0;
            col_q               <= col_d;
            row_q               <= row_d;
            runStart_q          <= runStartKept_d;
            state_q             <= stateAdv_d;
          end
        end
        PICK: begin
          // Out-of-range picks are rejected and retried with the next LFSR value.
          if (accept) begin
            hWalls_q[hPickIdx] <= 1'b0;
            col_q              <= col_d;
            row_q              <= row_d;
            runStart_q         <= runStartClosed_d;
            state_q            <= stateAdv_d;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
          state_q <= IDLE;
`ifdef MAZE_GEN_EXITS_EN
          hWalls_q[0]    <= 1'b0;
          hWalls_q[HW-1] <= 1'b0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign walls_valid = valid_q;
  assign h_walls     = hWalls_q;
  assign v_walls     = vWalls_q;

endmodule

// File: tb/tb_maze_generator.sv
// Self-checking bench for maze_generator: reset state, maze structure, repeatability, start-while-busy, mid-run reset.
module tb_maze_generator;

  localparam int C  = 10;
  localparam int R  = 15;
  localparam int HW = (R + 1) * C;
  localparam int VW = R * (C + 1);
`ifdef MAZE_GEN_EXITS_EN
  localparam int EXP_CLEARED = 151;
  localparam bit EXITS = 1'b1;
`else
  localparam int EXP_CLEARED = 149;
  localparam bit EXITS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, wallsValid;
  logic [HW-1:0] hWalls, hRef;
  logic [VW-1:0] vWalls, vRef;

  int compared = 0;
  int mismatched = 0;

  maze_generator #(.COLS(C), .ROWS(R), .SEED(16'hACE1)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .walls_valid (wallsValid),
    .h_walls     (hWalls),
    .v_walls     (vWalls)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic resetDut(input int cycles);
    rst   = 1'b0;
    start = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "Busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "Done"}, 32'(done), 32'd0);
    checkOutput({tag, "Valid"}, 32'(wallsValid), 32'd0);
    checkOutput({tag, "HAllOnes"}, 32'(&hWalls), 32'd1);
    checkOutput({tag, "VAllOnes"}, 32'(&vWalls), 32'd1);
  endtask

  // Counts cycles from the start edge to the first done and any extra done pulses after it.
  task automatic waitDone(input int pokeAt, output int firstDone, output int doneCount);
    int cycles;
    cycles    = 0;
    firstDone = -1;
    doneCount = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      start = (cycles == pokeAt);
      if (done) begin
        doneCount++;
        if (firstDone < 0) firstDone = cycles;
      end
      if (firstDone >= 0 && cycles >= firstDone + 10) break;
    end
    start = 1'b0;
  endtask

  task automatic checkMaze(input string tag);
    int cleared, borderOpen, reached, cur, r, c;
    bit visited [R*C];
    int queue [$];
    cleared    = 0;
    borderOpen = 0;
    for (int i = 0; i < HW; i++) if (!hWalls[i]) cleared++;
    for (int i = 0; i < VW; i++) if (!vWalls[i]) cleared++;
    for (int i = 0; i < C; i++) begin
      if (!hWalls[i] && !(EXITS && i == 0)) borderOpen++;
      if (!hWalls[R*C+i] && !(EXITS && i == C-1)) borderOpen++;
    end
    for (int i = 0; i < R; i++) begin
      if (!vWalls[i*(C+1)]) borderOpen++;
      if (!vWalls[i*(C+1)+C]) borderOpen++;
    end
    for (int i = 0; i < R*C; i++) visited[i] = 1'b0;
    visited[0] = 1'b1;
    reached    = 1;
    queue.push_back(0);
    while (queue.size() > 0) begin
      cur = queue.pop_front();
      r   = cur / C;
      c   = cur % C;
      if (r > 0 && !hWalls[r*C+c] && !visited[cur-C]) begin
        visited[cur-C] = 1'b1; reached++; queue.push_back(cur-C);
      end
      if (r < R-1 && !hWalls[(r+1)*C+c] && !visited[cur+C]) begin
        visited[cur+C] = 1'b1; reached++; queue.push_back(cur+C);
      end
      if (c > 0 && !vWalls[r*(C+1)+c] && !visited[cur-1]) begin
        visited[cur-1] = 1'b1; reached++; queue.push_back(cur-1);
      end
      if (c < C-1 && !vWalls[r*(C+1)+c+1] && !visited[cur+1]) begin
        visited[cur+1] = 1'b1; reached++; queue.push_back(cur+1);
      end
    end
    checkOutput({tag, "Cleared"}, 32'(cleared), 32'(EXP_CLEARED));
    checkOutput({tag, "BorderOpen"}, 32'(borderOpen), 32'd0);
    checkOutput({tag, "Reached"}, 32'(reached), 32'(R*C));
    checkOutput({tag, "TopRow"}, 32'(vWalls[C-1:1]), 32'd0);
    checkOutput({tag, "Entrance"}, 32'(hWalls[0]), EXITS ? 32'd0 : 32'd1);
    checkOutput({tag, "Exit"}, 32'(hWalls[HW-1]), EXITS ? 32'd0 : 32'd1);
  endtask

  initial begin
    int firstDone, doneCount;

    resetDut(3);
    checkReset("reset");
    rst = 1'b1;

    pulseStart();
    checkOutput("run1BusyAfterStart", 32'(busy), 32'd1);
    waitDone(-1, firstDone, doneCount);
    checkOutput("run1DoneCount", 32'(doneCount), 32'd1);
    checkOutput("run1Latency", 32'(firstDone >= 143), 32'd1);
    checkOutput("run1Valid", 32'(wallsValid), 32'd1);
    checkOutput("run1BusyIdle", 32'(busy), 32'd0);
    checkMaze("run1");
    hRef = hWalls;
    vRef = vWalls;

    resetDut(3);
    rst = 1'b1;
    pulseStart();
    waitDone(-1, firstDone, doneCount);
    checkOutput("run2DoneCount", 32'(doneCount), 32'd1);
    checkOutput("run2HSame", 32'(hWalls == hRef), 32'd1);
    checkOutput("run2VSame", 32'(vWalls == vRef), 32'd1);

    resetDut(3);
    rst = 1'b1;
    pulseStart();
    waitDone(20, firstDone, doneCount);
    checkOutput("pokeDoneCount", 32'(doneCount), 32'd1);
    checkOutput("pokeHSame", 32'(hWalls == hRef), 32'd1);
    checkOutput("pokeVSame", 32'(vWalls == vRef), 32'd1);

    resetDut(3);
    rst = 1'b1;
    pulseStart();
    repeat (49) @(posedge clk);
    #1;
    checkOutput("midRunBusy", 32'(busy), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkReset("midReset");
    rst = 1'b1;
    pulseStart();
    waitDone(-1, firstDone, doneCount);
    checkOutput("rerunDoneCount", 32'(doneCount), 32'd1);
    checkOutput("rerunValid", 32'(wallsValid), 32'd1);
    checkMaze("rerun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
